// File: rtl/riscv_regfile_pkg.sv
// rtl/riscv_regfile_pkg.sv - shared register-file constants and types
package riscv_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/riscv_regfile_wr_arb.sv
// rtl/riscv_regfile_wr_arb.sv - per-address write-port select, highest-indexed port wins
module riscv_regfile_wr_arb
    import riscv_regfile_pkg::*;
#(
    parameter int NUM_WRITE = 2,
    parameter int XLEN      = 32
) (
    input  reg_addr_t                       addr_i,
    input  logic [NUM_WRITE-1:0]            wr_en_i,
    input  logic [REG_ADDR_W*NUM_WRITE-1:0] wr_addr_i,
    input  logic [XLEN*NUM_WRITE-1:0]       wr_data_i,
    output logic                            hit_o,
    output logic [XLEN-1:0]                 data_o
);

    // Ascending scan so a later (higher-indexed) match overrides earlier ones.
    // x0 never hits: its writes are dropped and it is never bypassed.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en_i[k] && (wr_addr_i[REG_ADDR_W*k +: REG_ADDR_W] == addr_i) &&
                (addr_i != REG_ZERO)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[XLEN*k +: XLEN];
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mrnw.sv
// rtl/riscv_regfile_mrnw.sv - multi-read multi-write register file with pending-write scoreboard
module riscv_regfile_mrnw
    import riscv_regfile_pkg::*;
#(
    parameter int NUM_READ  = 4,
    parameter int NUM_WRITE = 2,
    parameter int XLEN      = 32,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_WRITE-1:0]            wr_en_i,
    input  logic [REG_ADDR_W*NUM_WRITE-1:0] wr_addr_i,
    input  logic [XLEN*NUM_WRITE-1:0]       wr_data_i,
    input  logic [REG_ADDR_W*NUM_READ-1:0]  rd_addr_i,
    output logic [XLEN*NUM_READ-1:0]        rd_data_o,
    output logic [NUM_READ-1:0]             rd_busy_o,
    input  logic                            sb_set_i,
    input  reg_addr_t                       sb_addr_i
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [NUM_REGS-1:0] wr_hit;
    logic [XLEN-1:0]     wr_sel [NUM_REGS];

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_store_arb
        riscv_regfile_wr_arb #(
            .NUM_WRITE (NUM_WRITE),
            .XLEN      (XLEN)
        ) u_store_arb (
            .addr_i    (reg_addr_t'(r)),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (wr_hit[r]),
            .data_o    (wr_sel[r])
        );
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = wr_hit[r] ? wr_sel[r] : regs_q[r];
        end
        regs_d[0] = '0;

        // Retiring writes clear; a same-cycle issue to the same register
        // re-arms it because the new producer is still outstanding.
        busy_d = busy_q & ~wr_hit;
        if (sb_set_i && (sb_addr_i != REG_ZERO)) begin
            busy_d[sb_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_read
        reg_addr_t       rd_addr;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic            set_same;

        assign rd_addr  = rd_addr_i[REG_ADDR_W*j +: REG_ADDR_W];
        assign set_same = sb_set_i && (sb_addr_i == rd_addr);

        riscv_regfile_wr_arb #(
            .NUM_WRITE (NUM_WRITE),
            .XLEN      (XLEN)
        ) u_byp_arb (
            .addr_i    (rd_addr),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (byp_hit),
            .data_o    (byp_data)
        );

        assign rd_data_o[XLEN*j +: XLEN] = (BYPASS && byp_hit) ? byp_data : regs_q[rd_addr];

        // A bypassed write resolves the hazard now, unless a new producer is
        // issued to the same register in this cycle.
        assign rd_busy_o[j] = busy_q[rd_addr] & ~(BYPASS && byp_hit && !set_same);
    end

endmodule

// File: tb/tb_riscv_regfile_mrnw.sv
// tb/tb_riscv_regfile_mrnw.sv - self-checking bench for riscv_regfile_mrnw, both bypass modes
module tb_riscv_regfile_mrnw;

    localparam int NR = 4;
    localparam int NW = 2;
    localparam int XL = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i;
    logic [NW-1:0]    wr_en;
    logic [5*NW-1:0]  wr_addr;
    logic [XL*NW-1:0] wr_data;
    logic [5*NR-1:0]  rd_addr;
    logic             sb_set;
    logic [4:0]       sb_addr;
    logic [XL*NR-1:0] rd_data_b1, rd_data_b0;
    logic [NR-1:0]    rd_busy_b1, rd_busy_b0;

    riscv_regfile_mrnw #(.NUM_READ(NR), .NUM_WRITE(NW), .XLEN(XL), .BYPASS(1'b1)) dut_b1 (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b1), .rd_busy_o(rd_busy_b1),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr)
    );

    riscv_regfile_mrnw #(.NUM_READ(NR), .NUM_WRITE(NW), .XLEN(XL), .BYPASS(1'b0)) dut_b0 (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b0), .rd_busy_o(rd_busy_b0),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra;
        logic        sb;
        logic [4:0]  sa;
        logic [31:0] d1, d0;
        logic        b1, b0;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    // Reference: architectural state plus the current cycle's requests.
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        v = m_regs[a];
        if (byp && a != 5'd0)
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wr_addr[5*k +: 5] == a) v = wr_data[32*k +: 32];
        return v;
    endfunction

    function automatic bit exp_busy(input logic [4:0] a, input bit byp);
        bit written;
        written = 1'b0;
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && wr_addr[5*k +: 5] == a && a != 5'd0) written = 1'b1;
        if (byp && written && !(sb_set && sb_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic commit();
        if (!rst_i) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wr_addr[5*k +: 5] != 5'd0) begin
                    m_regs[wr_addr[5*k +: 5]] = wr_data[32*k +: 32];
                    m_busy[wr_addr[5*k +: 5]] = 1'b0;
                end
            if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [4:0] a;
        for (int j = 0; j < NR; j++) begin
            a = rd_addr[5*j +: 5];
            chk("model_data_byp1", j, rd_data_b1[32*j +: 32], exp_data(a, 1'b1));
            chk("model_data_byp0", j, rd_data_b0[32*j +: 32], exp_data(a, 1'b0));
            chk("model_busy_byp1", j, {31'd0, rd_busy_b1[j]}, {31'd0, exp_busy(a, 1'b1)});
            chk("model_busy_byp0", j, {31'd0, rd_busy_b0[j]}, {31'd0, exp_busy(a, 1'b0)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'h12345678, 5'd5, 1'b0, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 5'd3, 1'b1, 5'd3, 32'h33, 32'h0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h33, 32'h33, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 2'b10, 5'd0, 5'd3, 32'h0, 32'h44, 5'd3, 1'b0, 5'd0, 32'h44, 32'h33, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h44, 32'h44, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 5'd9, 1'b1, 5'd10, 32'h55, 32'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};

        rst_i = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; sb_set = 1'b0; sb_addr = '0;
        #1;
        tick();
        tick();

        rst_i = 1'b1;
        for (int a = 0; a < 32; a += NR) begin
            for (int j = 0; j < NR; j++) rd_addr[5*j +: 5] = 5'(a + j);
            #1;
            for (int j = 0; j < NR; j++) begin
                chk("reset_data_byp1", a + j, rd_data_b1[32*j +: 32], 32'h0);
                chk("reset_data_byp0", a + j, rd_data_b0[32*j +: 32], 32'h0);
                chk("reset_busy", a + j, {30'd0, rd_busy_b1[j], rd_busy_b0[j]}, 32'h0);
            end
        end
        tick();

        for (int i = 0; i < 16; i++) begin
            rst_i   = tbl[i].rst;
            wr_en   = tbl[i].we;
            wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            rd_addr = {NR{tbl[i].ra}};
            sb_set  = tbl[i].sb;
            sb_addr = tbl[i].sa;
            @(negedge clk);
            for (int j = 0; j < NR; j++) begin
                chk($sformatf("vec%0d_data_byp1", i), j, rd_data_b1[32*j +: 32], tbl[i].d1);
                chk($sformatf("vec%0d_data_byp0", i), j, rd_data_b0[32*j +: 32], tbl[i].d0);
                chk($sformatf("vec%0d_busy_byp1", i), j, {31'd0, rd_busy_b1[j]}, {31'd0, tbl[i].b1});
                chk($sformatf("vec%0d_busy_byp0", i), j, {31'd0, rd_busy_b0[j]}, {31'd0, tbl[i].b0});
            end
            check_model();
            tick();
        end

        for (int n = 0; n < 600; n++) begin
            rst_i = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < NW; k++) begin
                wr_en[k]          = 1'($urandom_range(0, 1));
                wr_addr[5*k +: 5] = rnd_addr();
                wr_data[32*k +: 32] = $urandom;
            end
            for (int j = 0; j < NR; j++) rd_addr[5*j +: 5] = rnd_addr();
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = rnd_addr();
            @(negedge clk);
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
